// File: rtl/wavetable_ram_mp.sv
// -----------------------------------------------------------------------------
// wavetable_ram_mp
//
// Multi-voice wavetable memory. 2^ADDR_W words of DATA_W bits, split into
// 256-word banks (one EBR each). One host write port and NVOICE voice read
// ports share a single array access per cycle. Voices are served by a
// round-robin arbiter. The read path is a fixed two-cycle pipeline.
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   wr_req    in   host write request, held until wr_ack
//   wr_addr   in   write word address
//   wr_data   in   write data
//   wr_ack    out  one-cycle pulse, write committed on the previous edge
//   rd_req    in   per-voice read request, held until that voice's rd_gnt
//   rd_addr   in   voice v address at [v*ADDR_W +: ADDR_W]
//   rd_gnt    out  one-hot grant, combinational, read issued this cycle
//   rd_valid  out  rd_data / rd_voice valid this cycle
//   rd_voice  out  voice that owns rd_data
//   rd_data   out  read result
// -----------------------------------------------------------------------------
module wavetable_ram_mp #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter int NVOICE = 4,
    localparam int VID_W = $clog2(NVOICE)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    input  logic [NVOICE-1:0]        rd_req,
    input  logic [NVOICE*ADDR_W-1:0] rd_addr,
    output logic [NVOICE-1:0]        rd_gnt,
    output logic                     rd_valid,
    output logic [VID_W-1:0]         rd_voice,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int NBANK  = 1 << (ADDR_W - 8);
    localparam int BANK_W = (ADDR_W > 8) ? (ADDR_W - 8) : 1;

    // Arbitration / slot state
    logic [VID_W-1:0]  rr_q, rr_d;
    logic              prev_wr_q, prev_wr_d;
    logic              wr_ack_q, wr_ack_d;

    // Read pipeline: stage 1 tracks the access whose data sits in the bank
    // read register; stage 2 is the output register.
    logic              s1_valid_q, s1_valid_d;
    logic [VID_W-1:0]  s1_voice_q, s1_voice_d;
    logic [BANK_W-1:0] s1_bank_q, s1_bank_d;
    logic              rd_valid_q, rd_valid_d;
    logic [VID_W-1:0]  rd_voice_q, rd_voice_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    // Combinational slot decision
    logic              any_rd_s;
    logic              wr_take_s;
    logic              rd_take_s;
    logic              found_s;
    logic              scan_hit_s;
    logic [VID_W:0]    scan_idx_s;
    logic [VID_W-1:0]  gnt_id_s;
    logic [NVOICE-1:0] gnt_s;
    logic [ADDR_W-1:0] rd_sel_addr_s;
    logic [ADDR_W-1:0] acc_addr_s;
    logic [BANK_W-1:0] acc_bank_s;
    logic [7:0]        acc_row_s;
    logic [DATA_W-1:0] bank_rdata_s [NBANK];

    // Round-robin search: first requester at or after rr, wrapping at NVOICE-1.
    always_comb begin
        found_s    = 1'b0;
        gnt_id_s   = '0;
        scan_idx_s = '0;
        scan_hit_s = 1'b0;
        for (int i = 0; i < NVOICE; i++) begin
            scan_idx_s = {1'b0, rr_q} + (VID_W+1)'(i);
            scan_idx_s = (scan_idx_s >= (VID_W+1)'(NVOICE))
                         ? (scan_idx_s - (VID_W+1)'(NVOICE)) : scan_idx_s;
            scan_hit_s = ~found_s & rd_req[scan_idx_s[VID_W-1:0]];
            gnt_id_s   = scan_hit_s ? scan_idx_s[VID_W-1:0] : gnt_id_s;
            found_s    = found_s | scan_hit_s;
        end
    end

    // Slot selection. A write yields one slot after each write while reads
    // wait, so reads cannot starve. Nothing is issued while in reset.
    always_comb begin
        any_rd_s  = |rd_req;
        wr_take_s = rst_n & wr_req & ~(prev_wr_q & any_rd_s);
        rd_take_s = rst_n & ~wr_take_s & any_rd_s & found_s;
    end

    // One-hot grant for the issue cycle only.
    always_comb begin
        gnt_s           = '0;
        gnt_s[gnt_id_s] = rd_take_s;
    end

    assign rd_gnt = gnt_s;

    // Address of this cycle's single array access and its bank/row split.
    assign rd_sel_addr_s = rd_addr[int'(gnt_id_s)*ADDR_W +: ADDR_W];
    assign acc_addr_s    = wr_take_s ? wr_addr : rd_sel_addr_s;
    assign acc_row_s     = acc_addr_s[7:0];

    if (ADDR_W > 8) begin : g_bank_dec
        assign acc_bank_s = acc_addr_s[ADDR_W-1:8];
    end else begin : g_single_bank
        assign acc_bank_s = 1'b0;
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        logic [DATA_W-1:0] mem_q [256];
        logic [DATA_W-1:0] rdata_q;
        logic              bank_en_s;

        assign bank_en_s = (wr_take_s | rd_take_s) & (acc_bank_s == BANK_W'(b));

        // EBR bank: only the addressed bank is enabled; contents are not reset.
        always_ff @(posedge clk) begin
            if (bank_en_s) begin
                if (wr_take_s) begin
                    mem_q[acc_row_s] <= wr_data;
                end else begin
                    rdata_q <= mem_q[acc_row_s];
                end
            end
        end

        assign bank_rdata_s[b] = rdata_q;
    end

    // Next-state for arbiter, ack and read pipeline. The output mux uses the
    // bank index captured with the access, never the live address.
    always_comb begin
        rr_d = rd_take_s
               ? ((gnt_id_s == VID_W'(NVOICE - 1)) ? '0 : (gnt_id_s + VID_W'(1)))
               : rr_q;
        prev_wr_d  = wr_take_s;
        wr_ack_d   = wr_take_s;
        s1_valid_d = rd_take_s;
        s1_voice_d = rd_take_s ? gnt_id_s : s1_voice_q;
        s1_bank_d  = rd_take_s ? acc_bank_s : s1_bank_q;
        rd_valid_d = s1_valid_q;
        rd_voice_d = s1_valid_q ? s1_voice_q : rd_voice_q;
        rd_data_d  = s1_valid_q ? bank_rdata_s[s1_bank_q] : rd_data_q;
    end

    // State registers; reset drops any in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            prev_wr_q  <= 1'b0;
            wr_ack_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_voice_q <= '0;
            s1_bank_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_voice_q <= '0;
            rd_data_q  <= '0;
        end else begin
            rr_q       <= rr_d;
            prev_wr_q  <= prev_wr_d;
            wr_ack_q   <= wr_ack_d;
            s1_valid_q <= s1_valid_d;
            s1_voice_q <= s1_voice_d;
            s1_bank_q  <= s1_bank_d;
            rd_valid_q <= rd_valid_d;
            rd_voice_q <= rd_voice_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign wr_ack   = wr_ack_q;
    assign rd_valid = rd_valid_q;
    assign rd_voice = rd_voice_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_wavetable_ram_mp.sv
// -----------------------------------------------------------------------------
// Testbench for wavetable_ram_mp: default instance (9/16/4) plus a
// 10/12/3 instance. Inputs change 1 ns after the rising edge, outputs are
// sampled on the falling edge of the same cycle.
// -----------------------------------------------------------------------------
module tb_wavetable_ram_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    // Default instance
    logic        wr_req;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [3:0]  rd_req;
    logic [35:0] rd_addr;
    logic [3:0]  rd_gnt;
    logic        rd_valid;
    logic [1:0]  rd_voice;
    logic [15:0] rd_data;

    // Swept instance
    logic        wr_req2;
    logic [9:0]  wr_addr2;
    logic [11:0] wr_data2;
    logic        wr_ack2;
    logic [2:0]  rd_req2;
    logic [29:0] rd_addr2;
    logic [2:0]  rd_gnt2;
    logic        rd_valid2;
    logic [1:0]  rd_voice2;
    logic [11:0] rd_data2;

    int total = 0;
    int bad   = 0;

    wavetable_ram_mp u_dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_voice(rd_voice), .rd_data(rd_data)
    );

    wavetable_ram_mp #(.ADDR_W(10), .DATA_W(12), .NVOICE(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2),
        .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_gnt(rd_gnt2),
        .rd_valid(rd_valid2), .rd_voice(rd_voice2), .rd_data(rd_data2)
    );

    typedef struct {
        logic        wr;
        logic [8:0]  waddr;
        logic [15:0] wdata;
        logic [3:0]  req;
        logic [35:0] raddr;
        logic [3:0]  exp_gnt;
        logic        exp_ack;
        logic        exp_valid;
        logic [1:0]  exp_voice;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    localparam logic [35:0] RA    = {9'd51, 9'd35, 9'd19, 9'd3};
    localparam logic [35:0] RA403 = {9'd51, 9'd403, 9'd19, 9'd3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic wr, input logic [8:0] wa, input logic [15:0] wd,
                                 input logic [3:0] rq, input logic [35:0] ra,
                                 input logic [3:0] g, input logic ack, input logic vl,
                                 input logic [1:0] vo, input logic [15:0] d);
        vec_t r;
        r.wr = wr; r.waddr = wa; r.wdata = wd; r.req = rq; r.raddr = ra;
        r.exp_gnt = g; r.exp_ack = ack; r.exp_valid = vl; r.exp_voice = vo; r.exp_data = d;
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Round robin with all four voices (rr starts at 0 after reset)
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'hF, RA, 4'b0001, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'hF, RA, 4'b0010, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'hF, RA, 4'b0100, 1'b0, 1'b1, 2'd0, 16'hA5A6));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'hF, RA, 4'b1000, 1'b0, 1'b1, 2'd1, 16'hA5B6));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'hF, RA, 4'b0001, 1'b0, 1'b1, 2'd2, 16'hA586));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA, 4'b0000, 1'b0, 1'b1, 2'd3, 16'hA596));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA, 4'b0000, 1'b0, 1'b1, 2'd0, 16'hA5A6));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        // Write/read contention: six writes against voices 1 and 3 (rr = 1)
        vecs.push_back(mkv(1'b1, 9'd400, 16'hC000, 4'hA, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b1, 9'd401, 16'hC001, 4'hA, RA, 4'b0010, 1'b1, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b1, 9'd401, 16'hC001, 4'hA, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b1, 9'd402, 16'hC002, 4'hA, RA, 4'b1000, 1'b1, 1'b1, 2'd1, 16'hA5B6));
        vecs.push_back(mkv(1'b1, 9'd402, 16'hC002, 4'hA, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b1, 9'd403, 16'hC003, 4'hA, RA, 4'b0010, 1'b1, 1'b1, 2'd3, 16'hA596));
        vecs.push_back(mkv(1'b1, 9'd403, 16'hC003, 4'hA, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b1, 9'd404, 16'hC004, 4'hA, RA, 4'b1000, 1'b1, 1'b1, 2'd1, 16'hA5B6));
        vecs.push_back(mkv(1'b1, 9'd404, 16'hC004, 4'hA, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b1, 9'd405, 16'hC005, 4'hA, RA, 4'b0010, 1'b1, 1'b1, 2'd3, 16'hA596));
        vecs.push_back(mkv(1'b1, 9'd405, 16'hC005, 4'hA, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'hA, RA, 4'b1000, 1'b1, 1'b1, 2'd1, 16'hA5B6));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA, 4'b0000, 1'b0, 1'b1, 2'd3, 16'hA596));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        // Read back one of the contended writes
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h4, RA403, 4'b0100, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA403, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0));
        vecs.push_back(mkv(1'b0, 9'd0, 16'h0, 4'h0, RA403, 4'b0000, 1'b0, 1'b1, 2'd2, 16'hC003));

        wr_req = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 4'hF; rd_addr = RA;
        wr_req2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; rd_req2 = 3'b111; rd_addr2 = '0;

        // ---- Reset state (requests present, grants must stay low) ----
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_wr_ack", wr_ack, 1'b0);
        chk("rst_rd_voice", rd_voice, 2'd0);
        chk("rst_rd_data", rd_data, 16'h0);
        chk("rst_rd_gnt", rd_gnt, 4'b0000);
        chk("rst_rd_gnt2", rd_gnt2, 3'b000);
        chk("rst_rd_valid2", rd_valid2, 1'b0);
        tick();
        rst_n = 1'b1; rd_req = 4'h0; rd_req2 = 3'b000;

        // ---- Fill all 512 words with k ^ A5A5 ----
        for (int k = 0; k < 512; k++) begin
            wr_req = 1'b1; wr_addr = 9'(k); wr_data = 16'(k) ^ 16'hA5A5;
            @(negedge clk);
            chk("fill_wr_ack", wr_ack, (k > 0) ? 1'b1 : 1'b0);
            tick();
        end
        wr_req = 1'b0;
        @(negedge clk);
        chk("fill_last_ack", wr_ack, 1'b1);
        tick();

        // ---- Voice 0 reads 0..511 back to back ----
        for (int t = 0; t < 514; t++) begin
            rd_req = (t < 512) ? 4'b0001 : 4'b0000;
            rd_addr = '0;
            rd_addr[8:0] = 9'(t);
            @(negedge clk);
            if (t < 512) chk("seq_gnt", rd_gnt, 4'b0001);
            if (t == 0) chk("seq_ack_clear", wr_ack, 1'b0);
            if (t >= 2) begin
                chk("seq_valid", rd_valid, 1'b1);
                chk("seq_voice", rd_voice, 2'd0);
                chk("seq_data", rd_data, 16'(t - 2) ^ 16'hA5A5);
            end else begin
                chk("seq_valid_lat", rd_valid, 1'b0);
            end
            tick();
        end
        @(negedge clk);
        chk("seq_drain_valid", rd_valid, 1'b0);
        tick();

        // ---- Reset pulse so the table starts from rr = 0 ----
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // ---- Table-driven arbitration and contention ----
        for (int i = 0; i < vecs.size(); i++) begin
            wr_req = vecs[i].wr; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
            rd_req = vecs[i].req; rd_addr = vecs[i].raddr;
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), rd_gnt, vecs[i].exp_gnt);
            chk($sformatf("vec%0d_ack", i), wr_ack, vecs[i].exp_ack);
            chk($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_voice", i), rd_voice, vecs[i].exp_voice);
                chk($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            end
            tick();
        end

        // ---- Read-after-write: write 300 and voice 2 request in the same cycle ----
        wr_req = 1'b1; wr_addr = 9'd300; wr_data = 16'h1234;
        rd_req = 4'b0100; rd_addr = {9'd51, 9'd300, 9'd19, 9'd3};
        @(negedge clk);
        chk("raw_write_first", rd_gnt, 4'b0000);
        tick();
        wr_req = 1'b0;
        @(negedge clk);
        chk("raw_gnt", rd_gnt, 4'b0100);
        chk("raw_ack", wr_ack, 1'b1);
        tick();
        rd_req = 4'b0000;
        @(negedge clk);
        chk("raw_valid_early", rd_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("raw_valid", rd_valid, 1'b1);
        chk("raw_voice", rd_voice, 2'd2);
        chk("raw_data", rd_data, 16'h1234);
        tick();

        // ---- Reset mid-stream with two reads in flight (rr = 3 here) ----
        rd_req = 4'hF; rd_addr = RA;
        @(negedge clk);
        chk("mid_gnt_a", rd_gnt, 4'b1000);
        tick();
        @(negedge clk);
        chk("mid_gnt_b", rd_gnt, 4'b0001);
        tick();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_valid", rd_valid, 1'b0);
            chk("mid_rst_gnt", rd_gnt, 4'b0000);
            tick();
        end
        rst_n = 1'b1; rd_req = 4'b1010;
        @(negedge clk);
        chk("post_rst_gnt", rd_gnt, 4'b0010);
        chk("post_rst_valid0", rd_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("post_rst_gnt2", rd_gnt, 4'b1000);
        chk("post_rst_valid1", rd_valid, 1'b0);
        tick();
        rd_req = 4'b0000;
        @(negedge clk);
        chk("post_rst_valid2", rd_valid, 1'b1);
        chk("post_rst_voice", rd_voice, 2'd1);
        chk("post_rst_data", rd_data, 16'hA5B6);
        tick();

        // ---- Swept instance: 4 banks, 3 voices ----
        for (int b = 0; b < 4; b++) begin
            wr_req2 = 1'b1; wr_addr2 = 10'(b * 256 + 5); wr_data2 = 12'(b * 12'h111 + 12'h111);
            @(negedge clk);
            chk("sw_wr_ack", wr_ack2, (b > 0) ? 1'b1 : 1'b0);
            tick();
        end
        wr_req2 = 1'b0;
        @(negedge clk);
        chk("sw_wr_ack_last", wr_ack2, 1'b1);
        tick();
        rd_req2 = 3'b111; rd_addr2 = {10'h105, 10'h205, 10'h305};
        @(negedge clk);
        chk("sw_gnt0", rd_gnt2, 3'b001);
        tick();
        @(negedge clk);
        chk("sw_gnt1", rd_gnt2, 3'b010);
        tick();
        @(negedge clk);
        chk("sw_gnt2", rd_gnt2, 3'b100);
        chk("sw_v0_valid", rd_valid2, 1'b1);
        chk("sw_v0_voice", rd_voice2, 2'd0);
        chk("sw_v0_data", rd_data2, 12'h444);
        tick();
        @(negedge clk);
        chk("sw_gnt_wrap", rd_gnt2, 3'b001);
        chk("sw_v1_voice", rd_voice2, 2'd1);
        chk("sw_v1_data", rd_data2, 12'h333);
        tick();
        rd_req2 = 3'b010; rd_addr2 = {10'h105, 10'h005, 10'h305};
        @(negedge clk);
        chk("sw_gnt_b0", rd_gnt2, 3'b010);
        chk("sw_v2_voice", rd_voice2, 2'd2);
        chk("sw_v2_data", rd_data2, 12'h222);
        tick();
        rd_req2 = 3'b000;
        @(negedge clk);
        chk("sw_v0b_voice", rd_voice2, 2'd0);
        chk("sw_v0b_data", rd_data2, 12'h444);
        tick();
        @(negedge clk);
        chk("sw_b0_valid", rd_valid2, 1'b1);
        chk("sw_b0_voice", rd_voice2, 2'd1);
        chk("sw_b0_data", rd_data2, 12'h111);
        tick();
        @(negedge clk);
        chk("sw_idle_valid", rd_valid2, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wavetable_ram_mp.md
# wavetable_ram_mp

Parametrised multi-voice wavetable memory: 2^ADDR_W words of DATA_W bits, built from 256-word banks that map onto iCE40 EBR. One host write port loads or rewrites tables at run time; NVOICE voice read ports share the array through a round-robin arbiter with a fixed two-cycle, fully pipelined read path. It sits between the table loader and the per-voice oscillators, and replaces the fixed single-reader 512x16 table.

## Interface
Parameters:
- ADDR_W, 9, word address width; depth 2^ADDR_W; must be >= 8; bank count NBANK = 2^(ADDR_W-8)
- DATA_W, 16, sample width
- NVOICE, 4, number of read ports; 2..16
- VID_W, $clog2(NVOICE), voice-id width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  host write request; held until wr_ack
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- wr_ack  out  1  one-cycle pulse: write committed this edge
- rd_req  in  NVOICE  per-voice read request; held until that voice's rd_gnt
- rd_addr  in  NVOICE*ADDR_W  voice v address at [v*ADDR_W +: ADDR_W]
- rd_gnt  out  NVOICE  one-hot, combinational; read issued this cycle
- rd_valid  out  1  rd_data/rd_voice valid this cycle
- rd_voice  out  VID_W  voice that owns rd_data
- rd_data  out  DATA_W  read result

## Operation
- One array access per cycle: either one write or one read, never both.
- Slot selection for each cycle:
  - Write wins if wr_req=1, unless the previous slot was a write and any rd_req bit is set. Under contention, writes therefore get at most every other slot and reads cannot starve.
  - Otherwise, if any rd_req bit is set, the read arbiter grants.
  - If neither applies, the slot is idle.
- Read arbiter: round-robin pointer rr (VID_W bits). It grants the first requesting voice at or after rr, searching upward with wrap from NVOICE-1 to 0. After a grant to voice g, rr becomes g+1 mod NVOICE. rr does not move on write or idle slots.
- rd_gnt[g]=1 only in the issue cycle. A voice may change rd_addr or drop rd_req in the cycle after its grant. Back-to-back grants to the same voice are legal when it is the only requester.
- Bank decode:
  - bank = addr[ADDR_W-1:8]; row = addr[7:0].
  - Only the addressed bank is enabled.
  - The bank select for reads is pipelined with the data. The output mux uses the registered bank index, never the live address.
- Memory contents are not reset and are undefined at power-up.

## Timing
- Write: wr_req=1 and slot taken in cycle N → array updated at edge ending N; wr_ack=1 during N+1. The host drops or changes wr_req/wr_addr/wr_data in N+1.
- Read: grant in cycle N → EBR output registered at end of N+1 → rd_valid=1, rd_voice=g, rd_data valid during N+2.
- Latency is exactly 2 cycles. Throughput is 1 read/cycle with no write traffic.
- Ordering and coherence:
  - Results return in grant order.
  - A read granted in cycle N+1 or later after a write slot in N to the same address returns the new data.
  - Same-cycle write/read collisions cannot occur.
- rd_valid=0 → rd_voice and rd_data hold their last values; the bench must not check them.
- Reset (rst_n=0, asynchronous):
  - rd_valid=0, wr_ack=0, rd_voice=0, rd_data=0.
  - rr=0, "previous slot was write" flag=0.
  - Both pipeline valid stages are cleared.
  - rd_gnt=0 while rst_n=0.
- Reset mid-operation: in-flight reads are dropped, so no rd_valid appears for them after release. A write in its commit cycle at assertion may or may not land; the host reissues it.
- First cycle after release: normal arbitration starting from rr=0.

## Test plan
- Fill and read: write addr k with data k^16'hA5A5 for all 512 words (ADDR_W=9). Then voice 0 reads 0..511 back to back.
  - Required: each wr_ack 1 cycle after its slot.
  - Required: rd_data = k^16'hA5A5 exactly 2 cycles after each grant, including across the 255→256 bank boundary.
- Round-robin: all 4 rd_req held high with distinct addresses. Required: grants 0,1,2,3,0,… one per cycle; rd_voice follows the same sequence 2 cycles later.
- Write/read contention: wr_req held for 6 writes while voices 1 and 3 request continuously. Required: slot pattern W,R1,W,R3,W,R1,…; no two consecutive writes while a read is pending.
- Read-after-write: write 16'h1234 to addr 300 in cycle N, voice 2 requests addr 300 in N. Required: voice 2 granted in N+1; rd_data=16'h1234 in N+3.
- Reset mid-stream: assert rst_n=0 with two reads in flight, release after 3 cycles. Required:
  - rd_valid=0 during and after reset until a new grant.
  - First post-reset grant goes to the lowest-index requester.
- Parameter sweep: ADDR_W=10, DATA_W=12, NVOICE=3. Required: 4 banks addressed correctly; wrap 2→0 in the arbiter; rd_voice width 2.
